// File: rtl/btn_debounce_sched_pkg.sv
// Shared types, defaults and helpers for the button debounce scheduler.
package btn_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } state_t;

  localparam int N_BTN_DEF = 4;
  localparam int CNT_W_DEF = 21;

  // Ceiling log2, clamped to at least 1 so index ports are never zero-width.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce_sched_rr_arbiter.sv
// Combinational rotate-priority arbiter: the first set request at or after
// rr (wrapping modulo N_BTN) wins.
module rr_arbiter
  import btn_pkg::*;
#(
  parameter  int N_BTN = N_BTN_DEF,
  localparam int GW    = clog2(N_BTN)
) (
  input  logic [N_BTN-1:0] req,
  input  logic [GW-1:0]    rr,
  output logic [N_BTN-1:0] gnt,
  output logic [GW-1:0]    gnt_id,
  output logic             found
);

  int          pos;
  logic [GW-1:0] idx;

  // Walk the requests starting at rr and keep only the first hit.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    pos    = 0;
    idx    = '0;
    for (int i = 0; i < N_BTN; i++) begin
      pos = int'(rr) + i;
      if (pos >= N_BTN) pos = pos - N_BTN;
      idx = GW'(pos);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/btn_debounce_sched.sv
// Time-multiplexed push-button debouncer. One settle counter is lent
// round-robin to whichever button disagrees with its debounced level.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | counter free; pick next pending button from rr
//   ST_SETTLE | counter granted to button g; commit after T stable cycles
module btn_debounce_sched
  import btn_pkg::*;
#(
  parameter  int N_BTN = N_BTN_DEF,
  parameter  int CNT_W = CNT_W_DEF,
  localparam int GW    = clog2(N_BTN)
) (
  input  logic             CLK,
  input  logic             nrst,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] db_btn,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] rel,
  output logic             busy,
  output logic [GW-1:0]    grant_id
);

  // Terminal count T-1 where T = 2^(CNT_W-1); top counter bit never sets.
  localparam logic [CNT_W-1:0] SETTLE_LAST = {1'b0, {(CNT_W-1){1'b1}}};

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] s_sync;
  logic [N_BTN-1:0] pend;

  state_t           state;
  state_t           next_state;

  logic [N_BTN-1:0] g_oh;
  logic [GW-1:0]    g_id;
  logic [GW-1:0]    rr_q;
  logic [CNT_W-1:0] count_q;

  logic [N_BTN-1:0] arb_gnt;
  logic [GW-1:0]    arb_id;
  logic             arb_found;

  logic             take_grant;
  logic             do_abort;
  logic             do_commit;
  logic             g_stable_back;
  logic [GW-1:0]    rr_after_g;

  // Two-flop synchroniser on every raw pin.
  always_ff @(posedge CLK) begin
    if (!nrst) begin
      sync1  <= '0;
      s_sync <= '0;
    end else begin
      sync1  <= btn;
      s_sync <= sync1;
    end
  end

  assign pend = s_sync ^ db_btn;

  rr_arbiter #(
    .N_BTN (N_BTN)
  ) u_arb (
    .req    (pend),
    .rr     (rr_q),
    .gnt    (arb_gnt),
    .gnt_id (arb_id),
    .found  (arb_found)
  );

  // Granted button has fallen back to its debounced level (a bounce).
  assign g_stable_back = ((s_sync ^ db_btn) & g_oh) == '0;

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!nrst) state <= ST_IDLE;
    else       state <= next_state;
  end

  // FSM next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (arb_found) next_state = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (g_stable_back)               next_state = ST_IDLE;
        else if (count_q == SETTLE_LAST) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // FSM action decode driving the datapath registers.
  always_comb begin
    take_grant = 1'b0;
    do_abort   = 1'b0;
    do_commit  = 1'b0;
    rr_after_g = (g_id == GW'(N_BTN - 1)) ? '0 : g_id + 1'b1;
    case (state)
      ST_IDLE:   take_grant = arb_found;
      ST_SETTLE: begin
        do_abort  = g_stable_back;
        do_commit = !g_stable_back && (count_q == SETTLE_LAST);
      end
      default: ;
    endcase
  end

  // Grant latch, settle counter, round-robin pointer and debounced outputs.
  always_ff @(posedge CLK) begin
    if (!nrst) begin
      g_oh    <= '0;
      g_id    <= '0;
      rr_q    <= '0;
      count_q <= '0;
      db_btn  <= '0;
      press   <= '0;
      rel     <= '0;
      busy    <= 1'b0;
    end else begin
      press <= '0;
      rel   <= '0;
      busy  <= (next_state == ST_SETTLE);
      if (take_grant) begin
        g_oh    <= arb_gnt;
        g_id    <= arb_id;
        count_q <= '0;
      end else if (do_abort) begin
        rr_q <= rr_after_g;
      end else if (do_commit) begin
        db_btn <= (db_btn & ~g_oh) | (s_sync & g_oh);
        press  <= g_oh & s_sync;
        rel    <= g_oh & ~s_sync;
        rr_q   <= rr_after_g;
      end else if (state == ST_SETTLE) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign grant_id = g_id;

endmodule

// File: tb/tb_btn_debounce_sched.sv
// Directed bench for btn_debounce_sched with N_BTN=4, CNT_W=4 (T=8).
module tb_btn_debounce_sched;

  logic       CLK;
  logic       nrst;
  logic [3:0] btn;
  logic [3:0] db_btn;
  logic [3:0] press;
  logic [3:0] rel;
  logic       busy;
  logic [1:0] grant_id;

  int n_vec;
  int n_err;
  logic mon_en;
  logic [3:0] strobe_acc;
  int hit;

  btn_debounce_sched #(
    .N_BTN (4),
    .CNT_W (4)
  ) dut (
    .CLK      (CLK),
    .nrst     (nrst),
    .btn      (btn),
    .db_btn   (db_btn),
    .press    (press),
    .rel      (rel),
    .busy     (busy),
    .grant_id (grant_id)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
      strobe_acc = strobe_acc | press | rel;
    end
  endtask

  // At most one strobe bit per cycle.
  always @(negedge CLK) begin
    if (mon_en) chk("strobe_excl", 32'($countones(press | rel) <= 1), 1);
  end

  initial begin
    n_vec = 0; n_err = 0; mon_en = 1'b0; strobe_acc = '0; hit = -1;
    nrst = 1'b0; btn = 4'hF;
    tick(5);
    chk("rst_db", db_btn, 0);
    chk("rst_press", press, 0);
    chk("rst_rel", rel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gid", grant_id, 0);
    mon_en = 1'b1;
    btn = 4'h0; nrst = 1'b1;
    tick(4);
    chk("idle_busy", busy, 0);
    chk("idle_db", db_btn, 0);

    // clean press / release on button 1
    btn = 4'b0010;
    tick(3);
    chk("press_busy", busy, 1);
    chk("press_gid", grant_id, 1);
    tick(7);
    chk("press_db_early", db_btn, 0);
    chk("press_early", press, 0);
    tick(1);
    chk("press_db", db_btn, 4'b0010);
    chk("press_pulse", press, 4'b0010);
    tick(1);
    chk("press_single", press, 0);
    chk("press_idle", busy, 0);
    tick(5);
    btn = 4'b0000;
    tick(3);
    chk("rel_gid", grant_id, 1);
    tick(7);
    chk("rel_early", rel, 0);
    tick(1);
    chk("rel_pulse", rel, 4'b0010);
    chk("rel_db", db_btn, 0);
    tick(1);
    chk("rel_single", rel, 0);
    tick(3);

    // bounce on button 2 (rr is 2 here)
    strobe_acc = '0;
    btn = 4'b0100;
    tick(3);
    chk("bounce_busy", busy, 1);
    chk("bounce_gid", grant_id, 2);
    tick(1);
    btn = 4'b0000;
    tick(3);
    chk("bounce_abort", busy, 0);
    chk("bounce_rr", dut.rr_q, 3);
    tick(10);
    chk("bounce_nostrobe", strobe_acc, 0);
    chk("bounce_db", db_btn, 0);
    chk("bounce_idle", busy, 0);

    // simultaneous presses on buttons 0 and 3 from rr=0
    nrst = 1'b0; btn = 4'b0000;
    tick(2);
    nrst = 1'b1;
    chk("simul_rr", dut.rr_q, 0);
    btn = 4'b1001;
    tick(11);
    chk("simul_db0", db_btn, 4'b0001);
    chk("simul_press0", press, 4'b0001);
    tick(1);
    chk("simul_press0_end", press, 0);
    chk("simul_busy3", busy, 1);
    chk("simul_gid3", grant_id, 3);
    tick(7);
    chk("simul_press3_early", press, 0);
    chk("simul_db_mid", db_btn, 4'b0001);
    tick(1);
    chk("simul_press3", press, 4'b1000);
    chk("simul_db3", db_btn, 4'b1001);
    tick(1);
    chk("simul_press3_end", press, 0);
    chk("simul_idle", busy, 0);
    btn = 4'b0000;
    tick(22);
    chk("simul_rel_db", db_btn, 0);
    chk("simul_rel_idle", busy, 0);

    // starvation: button 0 toggles every 3 cycles, button 2 held
    btn = 4'b0101;
    for (int c = 1; c <= 40; c++) begin
      tick(1);
      if (db_btn[2] && hit < 0) hit = c;
      if (c % 3 == 0) btn[0] = ~btn[0];
    end
    chk("starve_latency", hit, 15);
    chk("starve_bound", 32'(hit >= 0 && hit <= 21), 1);

    // reset in the middle of a settle
    nrst = 1'b0; btn = 4'b0000;
    tick(2);
    nrst = 1'b1;
    tick(2);
    btn = 4'b0010;
    tick(8);
    chk("mid_count", dut.count_q, 5);
    nrst = 1'b0;
    tick(1);
    chk("mid_busy", busy, 0);
    chk("mid_db", db_btn, 0);
    chk("mid_press", press, 0);
    nrst = 1'b1;
    tick(10);
    chk("mid_db_early", db_btn, 0);
    tick(1);
    chk("mid_db_commit", db_btn, 4'b0010);
    chk("mid_press_commit", press, 4'b0010);
    tick(2);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
